// File: rtl/const_op_pkg.sv
// Shared types and constants for the constant-operation driver.
// Contents:
//   drv_state_t  - driver FSM states (IDLE, DRIVE, CAPTURE, RESP)
//   OP_ADD/OP_SUB - encodings of the datapath operation select
//   CONST_TABLE  - constants selected by MyConstantSelect
//   const_cmd_t  - one command as presented on the command port
package const_op_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } drv_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [7:0] CONST_TABLE [4] = '{8'd1, 8'd2, 8'd4, 8'd8};

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] sel;
        logic       op;
        logic       chain;
    } const_cmd_t;

endpackage

// File: rtl/const_op_model.sv
// Combinational reference of the constant-operation datapath.
// Computes a_i +/- CONST_TABLE[sel_i] nine bits wide; bit 8 is the carry
// on add and the borrow on subtract.
// Ports:
//   a_i      - operand A
//   sel_i    - constant select
//   op_i     - OP_ADD / OP_SUB
//   result_o - 9-bit expected result
module const_op_model
    import const_op_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [1:0] sel_i,
    input  logic       op_i,
    output logic [8:0] result_o
);

    logic [8:0] a_ext;
    logic [8:0] c_ext;

    assign a_ext    = {1'b0, a_i};
    assign c_ext    = {1'b0, CONST_TABLE[sel_i]};
    assign result_o = (op_i == OP_SUB) ? (a_ext - c_ext) : (a_ext + c_ext);

endmodule

// File: rtl/const_op_driver.sv
// Initiator for the 8-bit constant-operation datapath.
// Accepts a command, holds the datapath operands stable for SETTLE_CYCLES,
// captures the datapath result and offers it on the response port.
// Chained commands reuse the last captured result as operand A.
// Optional build macro CONST_OP_CHECK_EN adds rsp_mismatch / rsp_carry,
// produced from an internal const_op_model checker.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   cmd_valid/cmd_ready            - command handshake
//   cmd_data/sel/op/chain          - command fields
//   dp_input/dp_const_sel/dp_operation - datapath operand drives
//   dp_output                      - datapath result (combinational)
//   rsp_valid/rsp_ready/rsp_data   - response handshake and data
//   op_count                       - consumed responses, wrapping
//   rsp_mismatch, rsp_carry        - only with CONST_OP_CHECK_EN
module const_op_driver
    import const_op_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_data,
    input  logic [1:0]       cmd_sel,
    input  logic             cmd_op,
    input  logic             cmd_chain,
    output logic [7:0]       dp_input,
    output logic [1:0]       dp_const_sel,
    output logic             dp_operation,
    input  logic [7:0]       dp_output,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic [CNT_W-1:0] op_count
`ifdef CONST_OP_CHECK_EN
    ,
    output logic             rsp_mismatch,
    output logic             rsp_carry
`endif
);

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    drv_state_t       state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [7:0]       dp_input_q, dp_input_d;
    logic [1:0]       dp_sel_q, dp_sel_d;
    logic             dp_op_q, dp_op_d;
    // The captured response doubles as the "last result" for chaining:
    // both are written in CAPTURE and reset to 0 together.
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    const_cmd_t       cmd;

    assign cmd = '{data: cmd_data, sel: cmd_sel, op: cmd_op, chain: cmd_chain};

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        dp_input_d = dp_input_q;
        dp_sel_d   = dp_sel_q;
        dp_op_d    = dp_op_q;
        rsp_data_d = rsp_data_q;
        op_count_d = op_count_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dp_input_d = cmd.chain ? rsp_data_q : cmd.data;
                    dp_sel_d   = cmd.sel;
                    dp_op_d    = cmd.op;
                    settle_d   = SettleLoad;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_q == 4'd0) begin
                    state_d = CAPTURE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            CAPTURE: begin
                rsp_data_d = dp_output;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + CntOne;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            settle_q   <= 4'd0;
            dp_input_q <= 8'd0;
            dp_sel_q   <= 2'd0;
            dp_op_q    <= 1'b0;
            rsp_data_q <= 8'd0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            dp_input_q <= dp_input_d;
            dp_sel_q   <= dp_sel_d;
            dp_op_q    <= dp_op_d;
            rsp_data_q <= rsp_data_d;
            op_count_q <= op_count_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign rsp_data     = rsp_data_q;
    assign dp_input     = dp_input_q;
    assign dp_const_sel = dp_sel_q;
    assign dp_operation = dp_op_q;
    assign op_count     = op_count_q;

`ifdef CONST_OP_CHECK_EN
    logic [8:0] model_res;
    logic       mismatch_q;
    logic       carry_q;

    const_op_model u_model (
        .a_i      (dp_input_q),
        .sel_i    (dp_sel_q),
        .op_i     (dp_op_q),
        .result_o (model_res)
    );

    // Flags are captured alongside rsp_data so they stay aligned with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch_q <= 1'b0;
            carry_q    <= 1'b0;
        end else if (state_q == CAPTURE) begin
            mismatch_q <= (model_res[7:0] != dp_output);
            carry_q    <= model_res[8];
        end
    end

    assign rsp_mismatch = mismatch_q;
    assign rsp_carry    = carry_q;
`else
    // No checker in this build.
`endif

endmodule

// File: tb/tb_const_op_driver.sv
// Self-checking bench for const_op_driver with a behavioural datapath and
// a transaction-level reference model checked every cycle.
module tb_const_op_driver;

    localparam int unsigned S  = 2;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_data = 8'd0;
    logic [1:0]    cmd_sel = 2'd0;
    logic          cmd_op = 1'b0;
    logic          cmd_chain = 1'b0;
    logic [7:0]    dp_input;
    logic [1:0]    dp_const_sel;
    logic          dp_operation;
    logic [7:0]    dp_output;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [7:0]    rsp_data;
    logic [CW-1:0] op_count;
`ifdef CONST_OP_CHECK_EN
    logic          rsp_mismatch;
    logic          rsp_carry;
`endif

    const_op_driver #(
        .SETTLE_CYCLES (S),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_sel      (cmd_sel),
        .cmd_op       (cmd_op),
        .cmd_chain    (cmd_chain),
        .dp_input     (dp_input),
        .dp_const_sel (dp_const_sel),
        .dp_operation (dp_operation),
        .dp_output    (dp_output),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .op_count     (op_count)
`ifdef CONST_OP_CHECK_EN
        ,
        .rsp_mismatch (rsp_mismatch),
        .rsp_carry    (rsp_carry)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Plain integer arithmetic, result modulo 512.
    function automatic logic [8:0] ref_calc(input logic [7:0] a, input logic [1:0] sel,
                                            input logic op);
        int kt[4];
        int r;
        kt = '{1, 2, 4, 8};
        r = op ? (int'(a) - kt[sel]) : (int'(a) + kt[sel]);
        r = (r + 512) % 512;
        return 9'(r);
    endfunction

    // Behavioural datapath: true result, optionally corrupted, plus glitches
    // while the operands are settling.
    logic       corrupt = 1'b0;
    logic [7:0] glitch = 8'd0;
    logic [8:0] dp_true;
    always_comb begin
        dp_true   = ref_calc(dp_input, dp_const_sel, dp_operation);
        dp_output = dp_true[7:0] ^ (corrupt ? 8'hFF : 8'h00) ^ glitch;
    end

    int ready_mode = 1; // 0 low, 1 high, 2 random
    always @(posedge clk) begin
        #2;
        rsp_ready = (ready_mode == 1) || (ready_mode == 2 && ($urandom % 2) == 1);
    end

    // Reference model: one outstanding transaction, response visible from
    // S+2 cycles after its handshake until consumed.
    bit         started = 0;
    bit         in_flight = 0;
    bit         vis;
    int         c = 0;
    int         hs = 0;
    int         count = 0;
    logic [7:0] m_in = 8'd0;
    logic [1:0] m_sel = 2'd0;
    logic       m_op = 1'b0;
    logic [7:0] last = 8'd0;
    logic [8:0] exp_full = 9'd0;
    logic [7:0] exp_data = 8'd0;
    logic       exp_corrupt = 1'b0;

    always @(negedge clk) begin
        vis = in_flight && (c - hs >= int'(S) + 2);
        if (started) begin
            chk("cmd_ready", cmd_ready, !in_flight);
            chk("rsp_valid", rsp_valid, vis);
            chk("rsp_data", rsp_data, vis ? exp_data : last);
            chk("dp_input", dp_input, m_in);
            chk("dp_const_sel", dp_const_sel, m_sel);
            chk("dp_operation", dp_operation, m_op);
            chk("op_count", op_count, count);
`ifdef CONST_OP_CHECK_EN
            if (vis) begin
                chk("rsp_mismatch", rsp_mismatch, exp_corrupt);
                chk("rsp_carry", rsp_carry, exp_full[8]);
            end
`endif
        end
        if (started && in_flight && (c - hs >= 1) && (c - hs <= int'(S)))
            glitch = 8'($urandom);
        else
            glitch = 8'd0;
        if (reset) begin
            started   = 1;
            in_flight = 0;
            m_in      = 8'd0;
            m_sel     = 2'd0;
            m_op      = 1'b0;
            last      = 8'd0;
            count     = 0;
        end else if (started) begin
            if (!in_flight && cmd_valid) begin
                in_flight   = 1;
                hs          = c;
                m_in        = cmd_chain ? last : cmd_data;
                m_sel       = cmd_sel;
                m_op        = cmd_op;
                exp_full    = ref_calc(m_in, m_sel, m_op);
                exp_corrupt = corrupt;
                exp_data    = exp_full[7:0] ^ (corrupt ? 8'hFF : 8'h00);
            end else if (vis && rsp_ready) begin
                in_flight = 0;
                last      = exp_data;
                count     = (count + 1) % (1 << CW);
            end
        end
        c++;
    end

    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic o,
                        input logic ch, output int hs_cyc);
        bit rdy;
        bit ok;
        ok = 0;
        cmd_data = d; cmd_sel = s; cmd_op = o; cmd_chain = ch; cmd_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin ok = 1; break; end
        end
        if (!ok) chk("handshake_timeout", 0, 1);
        cmd_valid = 1'b0;
        hs_cyc = cyc - 1;
    endtask

    task automatic wait_rsp(output int at);
        bit ok;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            if (rsp_valid) begin ok = 1; break; end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("rsp_timeout", 0, 1);
        at = cyc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int h, a, k;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_op_count", op_count, 0);
        chk("reset_rsp_data", rsp_data, 0);

        // Basic add with latency.
        send(8'd5, 2'd1, 1'b0, 1'b0, h);
        chk("t1_dp_input", dp_input, 5);
        chk("t1_dp_sel", dp_const_sel, 1);
        wait_rsp(a);
        chk("t1_latency", a - h, 4);
        chk("t1_rsp_data", rsp_data, 7);
        step();
        chk("t1_op_count", op_count, 1);

        // Subtract wrapping below zero, then chained add.
        send(8'd5, 2'd3, 1'b1, 1'b0, h);
        wait_rsp(a);
        chk("t2_sub", rsp_data, 253);
`ifdef CONST_OP_CHECK_EN
        chk("t2_carry", rsp_carry, 1);
`endif
        step();
        send(8'd99, 2'd0, 1'b0, 1'b1, h);
        wait_rsp(a);
        chk("t2_chain", rsp_data, 254);
`ifdef CONST_OP_CHECK_EN
        chk("t2_chain_carry", rsp_carry, 0);
`endif
        step();

        // Backpressure with a waiting command.
        ready_mode = 0;
        send(8'h20, 2'd2, 1'b0, 1'b0, h);
        wait_rsp(a);
        cmd_data = 8'd3; cmd_sel = 2'd0; cmd_op = 1'b1; cmd_chain = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 36);
            chk("bp_dp_input", dp_input, 32);
            chk("bp_cmd_ready", cmd_ready, 0);
            step();
        end
        ready_mode = 1;
        k = cyc;
        send(8'd3, 2'd0, 1'b1, 1'b0, h);
        chk("bp_accept_cycle", h, k + 1);
        wait_rsp(a);
        chk("bp_second", rsp_data, 2);
        step();

        // Reset while driving.
        send(8'd9, 2'd2, 1'b0, 1'b0, h);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_dp_input", dp_input, 0);
        chk("rst_dp_sel", dp_const_sel, 0);
        chk("rst_op_count", op_count, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen = 1;
            step();
        end
        chk("rst_no_rsp", seen, 0);
        send(8'd77, 2'd1, 1'b0, 1'b1, h);
        wait_rsp(a);
        chk("rst_chain_zero", rsp_data, 2);
        step();

        // Wrong datapath value.
        corrupt = 1'b1;
        send(8'd10, 2'd0, 1'b0, 1'b0, h);
        wait_rsp(a);
        chk("bad_rsp_data", rsp_data, 244);
`ifdef CONST_OP_CHECK_EN
        chk("bad_mismatch", rsp_mismatch, 1);
`endif
        step();
        corrupt = 1'b0;
        send(8'd10, 2'd0, 1'b0, 1'b0, h);
        wait_rsp(a);
        chk("good_rsp_data", rsp_data, 11);
`ifdef CONST_OP_CHECK_EN
        chk("good_mismatch", rsp_mismatch, 0);
`endif
        step();

        // Random traffic with random backpressure.
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 2'($urandom), 1'($urandom), 1'(($urandom % 3) == 0), h);
            repeat ($urandom % 3) step();
        end
        for (int n = 0; n < 200 && !cmd_ready; n++) step();

        // Counter wrap.
        ready_mode = 1;
        step();
        for (int n = 0; n < 40 && op_count != 4'd15; n++) begin
            send(8'($urandom), 2'($urandom), 1'($urandom), 1'b0, h);
            wait_rsp(a);
            step();
        end
        chk("wrap_pre", op_count, 15);
        send(8'd1, 2'd0, 1'b0, 1'b0, h);
        wait_rsp(a);
        step();
        chk("wrap_zero", op_count, 0);

        repeat (4) step();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
